vga_scan_reader: RTL

- Display-side reader for the 12-bit screen buffers. The CPU writes these buffers through the data-memory port; this block reads them.
- Generates 800x600@72Hz VGA timing from a single pixel clock.
- Issues the read address, fetch-aligned, to the screen buffer's read port, and receives the selected buffer's pixel one cycle later.
- Upscales a 200x150 buffer by 4 in both axes and drives the registered RGB444, HS and VS pins, plus a vblank flag for tear-free CPU updates.

---
 rtl/vga_scan_reader.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/vga_scan_reader.sv
// vga_scan_reader: display-side reader for a 12-bit screen buffer.
//
// Generates 800x600@72Hz VGA timing from the pixel clock. It fetches buffer
// pixels through a registered read address. The 200x150 buffer is upscaled by
// 4 in both axes. All pins are driven from registers that line up on the same
// edge.
//
// Ports:
//   clk          pixel clock
//   rst          synchronous reset, active-high
//   fb_addr      registered read address to the screen-buffer read port
//   fb_data      pixel {R,G,B} from the buffer, valid one clk after fb_addr
//   pattern_sel  (VGA_TEST_PATTERN_EN only) 1 = show colour bars instead of fb_data
//   vga_r/g/b    registered RGB444 pins
//   vga_hs/vs    sync pins, active-high
//   vblank       high while the pins show lines outside the active area
//   frame_start  one-clk pulse alongside the first active pixel of each frame
//
// Optional build macro: VGA_TEST_PATTERN_EN adds pattern_sel and the colour-bar
// generator. Without it there is no pattern_sel port, and the block always
// shows buffer data.
module vga_scan_reader #(
  parameter int unsigned H_ACTIVE   = 800,
  parameter int unsigned H_FP       = 56,
  parameter int unsigned H_SYNC     = 120,
  parameter int unsigned H_BP       = 64,
  parameter int unsigned V_ACTIVE   = 600,
  parameter int unsigned V_FP       = 37,
  parameter int unsigned V_SYNC     = 6,
  parameter int unsigned V_BP       = 23,
  parameter int unsigned SCALE_LOG2 = 2,
  parameter int unsigned FB_W       = 200,
  parameter int unsigned ADDR_W     = 15
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] fb_addr,
  input  logic [11:0]       fb_data,
`ifdef VGA_TEST_PATTERN_EN
  input  logic              pattern_sel,
`endif
  output logic [3:0]        vga_r,
  output logic [3:0]        vga_g,
  output logic [3:0]        vga_b,
  output logic              vga_hs,
  output logic              vga_vs,
  output logic              vblank,
  output logic              frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [ADDR_W-1:0] FB_W_C = ADDR_W'(FB_W);

  // Counters and address generator (stage 0)
  logic [HW-1:0]     hcnt_q, hcnt_d;
  logic [VW-1:0]     vcnt_q, vcnt_d;
  logic [ADDR_W-1:0] row_q, row_d;
  logic [ADDR_W-1:0] col_q, col_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              line_end, frame_end;
  logic              active0, hs0, vs0, vb0, fs0;

  // Three-deep delay lines; bit 2 drives the pins
  logic [2:0]        act_q, hs_q, vs_q, vb_q, fs_q;
  logic [11:0]       rgb_q, rgb_d;

  always_comb begin
    line_end  = (hcnt_q == H_LAST);
    frame_end = line_end && (vcnt_q == V_LAST);

    active0 = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
    hs0     = (hcnt_q >= HS_BEG) && (hcnt_q <= HS_END);
    vs0     = (vcnt_q >= VS_BEG) && (vcnt_q <= VS_END);
    vb0     = (vcnt_q >= V_ACT);
    fs0     = (hcnt_q == '0) && (vcnt_q == '0);

    hcnt_d = hcnt_q + 1'b1;
    vcnt_d = vcnt_q;
    if (line_end) begin
      hcnt_d = '0;
      vcnt_d = frame_end ? '0 : vcnt_q + 1'b1;
    end

    // Column steps once per upscaled pixel: after the last sub-pixel of each group
    col_d = col_q;
    if (line_end) begin
      col_d = '0;
    end else if (active0 && (&hcnt_q[SCALE_LOG2-1:0])) begin
      col_d = col_q + 1'b1;
    end

    // Row base advances after the last repeated line of each buffer row,
    // replacing a (vcnt>>SCALE_LOG2)*FB_W multiply
    row_d = row_q;
    if (frame_end) begin
      row_d = '0;
    end else if (line_end && (vcnt_q < V_ACT) && (&vcnt_q[SCALE_LOG2-1:0])) begin
      row_d = row_q + FB_W_C;
    end

    addr_d = active0 ? (row_q + col_q) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
      row_q  <= '0;
      col_q  <= '0;
      addr_q <= '0;
      act_q  <= '0;
      hs_q   <= '0;
      vs_q   <= '0;
      vb_q   <= '0;
      fs_q   <= '0;
      rgb_q  <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      row_q  <= row_d;
      col_q  <= col_d;
      addr_q <= addr_d;
      act_q  <= {act_q[1:0], active0};
      hs_q   <= {hs_q[1:0], hs0};
      vs_q   <= {vs_q[1:0], vs0};
      vb_q   <= {vb_q[1:0], vb0};
      fs_q   <= {fs_q[1:0], fs0};
      rgb_q  <= rgb_d;
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  localparam int unsigned BAR_W = H_ACTIVE / 8;

  // hcnt delayed to line up with fb_data, so bars land on the same pixels
  logic [HW-1:0] hd1_q, hd2_q;
  logic [2:0]    bar_idx;
  logic [11:0]   bar_rgb;

  always_ff @(posedge clk) begin
    if (rst) begin
      hd1_q <= '0;
      hd2_q <= '0;
    end else begin
      hd1_q <= hcnt_q;
      hd2_q <= hd1_q;
    end
  end

  always_comb begin
    bar_idx = '0;
    for (int unsigned i = 1; i < 8; i++) begin
      if (hd2_q >= HW'(i * BAR_W)) begin
        bar_idx = 3'(i);
      end
    end
    // Order white, yellow, cyan, green, magenta, red, blue, black
    bar_rgb = {{4{~bar_idx[1]}}, {4{~bar_idx[2]}}, {4{~bar_idx[0]}}};
  end
`endif

  // Stage 3: the buffer pixel is taken only here, blanked outside the active area
  always_comb begin
    rgb_d = '0;
    if (act_q[1]) begin
      rgb_d = fb_data;
`ifdef VGA_TEST_PATTERN_EN
      if (pattern_sel) begin
        rgb_d = bar_rgb;
      end
`endif
    end
  end

  assign fb_addr     = addr_q;
  assign vga_r       = rgb_q[11:8];
  assign vga_g       = rgb_q[7:4];
  assign vga_b       = rgb_q[3:0];
  assign vga_hs      = hs_q[2];
  assign vga_vs      = vs_q[2];
  assign vblank      = vb_q[2];
  assign frame_start = fs_q[2];

endmodule
